// File: rtl/tx_arb_pkg.sv
// Shared types and helpers for the round-robin transmit arbiter.
package tx_arb_pkg;

  // Arbiter lock state: free to pick a new source, or locked to a burst owner.
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_t;

  // Next round-robin start position: the source after idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority selector: the first active request
// found when scanning upward from ptr (wrapping past NUM_REQ-1) wins.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Scan candidates in priority order and keep the first active one.
  always_comb begin
    logic [ID_W-1:0] cand;
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(ptr) + 32'(k)) % 32'(NUM_REQ));
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_rr_arbiter.sv
// Round-robin arbiter with burst lock sharing one VALID/READY transmit
// channel between NUM_REQ sources, with a one-entry registered output.
module tx_rr_arbiter
  import tx_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     VALID,
  input  logic                     READY,
  output logic [WIDTH-1:0]         xDATA,
  output logic [ID_W-1:0]          xID,
  output logic                     xLAST,
  output logic                     busy
);

  arb_state_t         state;
  logic [ID_W-1:0]    owner;
  logic [ID_W-1:0]    ptr;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

  logic [ID_W-1:0]    sel;
  logic               sel_valid;
  logic               sel_last;
  logic [WIDTH-1:0]   sel_data;
  logic               load_ok;
  logic               take;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // The output register may accept a beat when empty or being emptied now.
  assign load_ok = !VALID || READY;

  // While locked only the owner is eligible; otherwise the round-robin winner.
  always_comb begin
    sel       = pick_idx;
    sel_valid = pick_any;
    if (state == LOCKED) begin
      sel       = owner;
      sel_valid = req_valid[owner];
    end
  end

  // Reset forces every handshake low even though the scan still sees requests.
  assign take     = sel_valid && load_ok && !ARESET;
  assign sel_data = req_data[sel*WIDTH +: WIDTH];
  assign sel_last = req_last[sel];

  // One-hot ready to the source whose beat is being taken this cycle.
  always_comb begin
    req_ready = '0;
    if (take) begin
      if (state == LOCKED) req_ready[owner] = 1'b1;
      else                 req_ready = pick_grant;
    end
  end

  assign busy = (state == LOCKED) || VALID;

  // Output register, burst lock and round-robin pointer.
  always_ff @(posedge ACLK or posedge ARESET) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (ARESET) begin
      state <= UNLOCKED;
      owner <= '0;
      ptr   <= '0;
      VALID <= 1'b0;
      xDATA <= '0;
      xID   <= '0;
      xLAST <= 1'b0;
    end else if (take) begin
      VALID <= 1'b1;
      xDATA <= sel_data;
      xID   <= sel;
      xLAST <= sel_last;
      if (sel_last) begin
        state <= UNLOCKED;
        ptr   <= ID_W'(rr_next(32'(sel), 32'(NUM_REQ)));
      end else begin
        state <= LOCKED;
        owner <= sel;
      end
    end else if (READY) begin
      VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_rr_arbiter.sv
// Self-checking bench for tx_rr_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_tx_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic             ACLK = 1'b0;
  logic             ARESET;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic             VALID;
  logic             READY;
  logic [W-1:0]     xDATA;
  logic [IW-1:0]    xID;
  logic             xLAST;
  logic             busy;

  tx_rr_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .VALID     (VALID),
    .READY     (READY),
    .xDATA     (xDATA),
    .xID       (xID),
    .xLAST     (xLAST),
    .busy      (busy)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic set_in(input logic [N-1:0] rv, input logic [N-1:0] rl, input logic rdy);
    req_valid = rv;
    req_last  = rl;
    READY     = rdy;
  endtask

  // Source i presents byte {i, row} so the expected payload is easy to read.
  task automatic set_data(input int row);
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(i * 16 + row);
  endtask

  // Behavioural model: channel contents, lock owner (-1 = none), start pointer.
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_id;
  bit           m_last;
  int           m_owner;
  int           m_ptr;

  function automatic void model_reset();
    m_valid = 1'b0; m_data = '0; m_id = 0; m_last = 1'b0; m_owner = -1; m_ptr = 0;
  endfunction

  // Source whose beat is accepted this cycle under the current inputs, or -1.
  function automatic int model_winner();
    if (m_valid && !READY) return -1;
    if (m_owner >= 0) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int s;
      s = (m_ptr + k) % N;
      if (req_valid[s]) return s;
    end
    return -1;
  endfunction

  function automatic void model_step(input int w);
    if (w >= 0) begin
      m_valid = 1'b1;
      m_data  = req_data[w*W +: W];
      m_id    = w;
      m_last  = req_last[w];
      if (req_last[w]) begin
        m_owner = -1;
        m_ptr   = (w + 1) % N;
      end else begin
        m_owner = w;
      end
    end else if (READY) begin
      m_valid = 1'b0;
    end
  endfunction

  typedef struct packed {
    logic [N-1:0]  rv;
    logic [N-1:0]  rl;
    logic          rdy;
    logic [N-1:0]  exp_rr;
    logic          exp_v;
    logic [IW-1:0] exp_id;
    logic          exp_l;
    logic [W-1:0]  exp_d;
  } vec_t;

  vec_t vecs [13];
  int   w;
  logic [N-1:0] exp_rr;

  initial begin
    // Alternating single beats, a locked 3-beat burst with a waiting rival,
    // a stall, a reload on READY, and a drain.
    vecs[0]  = '{4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 8'h00};
    vecs[1]  = '{4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 8'h21};
    vecs[2]  = '{4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 8'h02};
    vecs[3]  = '{4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 8'h23};
    vecs[4]  = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 8'h14};
    vecs[5]  = '{4'b1010, 4'b1000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 8'h15};
    vecs[6]  = '{4'b1010, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 8'h16};
    vecs[7]  = '{4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 8'h37};
    vecs[8]  = '{4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 8'h37};
    vecs[9]  = '{4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 8'h37};
    vecs[10] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 8'h0A};
    vecs[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 8'h0A};
    vecs[12] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 8'h0A};

    // Reset values, with requests pending so req_ready must be forced low.
    ARESET   = 1'b1;
    set_in(4'b1111, 4'b1111, 1'b1);
    req_data = '1;
    #2;
    check("reset VALID", 32'(VALID), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset xDATA", 32'(xDATA), 32'd0);
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    set_in(4'b0000, 4'b0000, 1'b1);

    // Idle after reset.
    for (int c = 0; c < 10; c++) begin
      #1;
      check("idle req_ready", 32'(req_ready), 32'd0);
      tick();
      check("idle VALID", 32'(VALID), 32'd0);
      check("idle busy", 32'(busy), 32'd0);
      check("idle xDATA", 32'(xDATA), 32'd0);
    end

    // Directed vector table.
    for (int r = 0; r < 13; r++) begin
      set_in(vecs[r].rv, vecs[r].rl, vecs[r].rdy);
      set_data(r);
      #1;
      check($sformatf("vec%0d req_ready", r), 32'(req_ready), 32'(vecs[r].exp_rr));
      tick();
      check($sformatf("vec%0d VALID", r), 32'(VALID), 32'(vecs[r].exp_v));
      check($sformatf("vec%0d xID", r), 32'(xID), 32'(vecs[r].exp_id));
      check($sformatf("vec%0d xLAST", r), 32'(xLAST), 32'(vecs[r].exp_l));
      check($sformatf("vec%0d xDATA", r), 32'(xDATA), 32'(vecs[r].exp_d));
    end

    // Stall with 0x5C on the bus, then reload in the same cycle READY returns.
    set_in(4'b0001, 4'b0001, 1'b1);
    req_data[7:0] = 8'h5C;
    #1;
    check("stall grant0", 32'(req_ready), 32'b0001);
    tick();
    check("stall load", 32'(xDATA), 32'h5C);
    set_in(4'b0010, 4'b0010, 1'b0);
    req_data[15:8] = 8'h77;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("stall req_ready", 32'(req_ready), 32'd0);
      tick();
      check("stall VALID", 32'(VALID), 32'd1);
      check("stall xDATA", 32'(xDATA), 32'h5C);
      check("stall xID", 32'(xID), 32'd0);
      check("stall xLAST", 32'(xLAST), 32'd1);
    end
    READY = 1'b1;
    #1;
    check("unstall req_ready", 32'(req_ready), 32'b0010);
    tick();
    check("unstall VALID", 32'(VALID), 32'd1);
    check("unstall xDATA", 32'(xDATA), 32'h77);
    check("unstall xID", 32'(xID), 32'd1);

    // Reset in the middle of a burst from source 2.
    set_in(4'b0100, 4'b0000, 1'b1);
    req_data[23:16] = 8'hB1;
    #1;
    check("burst2 b1 ready", 32'(req_ready), 32'b0100);
    tick();
    req_data[23:16] = 8'hB2;
    #1;
    check("burst2 b2 ready", 32'(req_ready), 32'b0100);
    tick();
    check("burst2 xDATA", 32'(xDATA), 32'hB2);
    check("burst2 busy", 32'(busy), 32'd1);
    ARESET = 1'b1;
    set_in(4'b0101, 4'b0101, 1'b1);
    #1;
    check("midreset VALID", 32'(VALID), 32'd0);
    check("midreset xDATA", 32'(xDATA), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset req_ready", 32'(req_ready), 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    check("postreset ready", 32'(req_ready), 32'b0001);
    tick();
    check("postreset xID", 32'(xID), 32'd0);
    check("postreset VALID", 32'(VALID), 32'd1);
    set_in(4'b0011, 4'b0011, 1'b1);
    #1;
    check("postreset rr", 32'(req_ready), 32'b0010);
    tick();
    check("postreset xID1", 32'(xID), 32'd1);

    // Owner drops req_valid mid-burst: lock holds, channel drains.
    set_in(4'b0010, 4'b0000, 1'b1);
    #1;
    check("drop lock ready", 32'(req_ready), 32'b0010);
    tick();
    check("drop xLAST", 32'(xLAST), 32'd0);
    set_in(4'b1001, 4'b1001, 1'b1);
    for (int c = 0; c < 2; c++) begin
      #1;
      check("drop req_ready", 32'(req_ready), 32'd0);
      tick();
      check("drop VALID", 32'(VALID), 32'd0);
      check("drop busy", 32'(busy), 32'd1);
    end

    // Randomized traffic against the model.
    ARESET = 1'b1;
    #1;
    check("rand reset VALID", 32'(VALID), 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) req_last[i] = ($urandom_range(0, 2) == 0);
      READY    = ($urandom_range(0, 3) != 0);
      req_data = $urandom;
      #1;
      w      = model_winner();
      exp_rr = (w >= 0) ? N'(1 << w) : '0;
      check("rand req_ready", 32'(req_ready), 32'(exp_rr));
      model_step(w);
      tick();
      check("rand VALID", 32'(VALID), 32'(m_valid));
      check("rand busy", 32'(busy), 32'(m_valid || (m_owner >= 0)));
      if (m_valid) begin
        check("rand xDATA", 32'(xDATA), 32'(m_data));
        check("rand xID", 32'(xID), 32'(m_id));
        check("rand xLAST", 32'(xLAST), 32'(m_last));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
